// File: rtl/collision_pair_scheduler.sv
// Walks every ball pair (i<j) once per pass, launches the velocity solver on overlapping and
// approaching pairs, and writes the solver's velocities back. Optional stats: COLLISION_STATS_EN.
module collision_pair_scheduler #(
  parameter int               WIDTH          = 32,
  parameter int               FRAC_WIDTH     = 30,
  parameter int               NUM_BALLS      = 16,
  parameter int               IDX_W          = 8,
  parameter logic [WIDTH-1:0] DIAM_SQ        = 32'h0100_0000,
  parameter int               SOLVER_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             pass_done,
  output logic             timeout_err,
  output logic [IDX_W-1:0] rd_addr,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_x,
  input  logic [WIDTH-1:0] rd_y,
  input  logic [WIDTH-1:0] rd_vx,
  input  logic [WIDTH-1:0] rd_vy,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_vx,
  output logic [WIDTH-1:0] wr_vy,
  output logic             sol_start,
  output logic [WIDTH-1:0] sol_x0,
  output logic [WIDTH-1:0] sol_y0,
  output logic [WIDTH-1:0] sol_vx0,
  output logic [WIDTH-1:0] sol_vy0,
  output logic [WIDTH-1:0] sol_x1,
  output logic [WIDTH-1:0] sol_y1,
  output logic [WIDTH-1:0] sol_vx1,
  output logic [WIDTH-1:0] sol_vy1,
  input  logic             sol_done,
  input  logic [WIDTH-1:0] sol_v0_x,
  input  logic [WIDTH-1:0] sol_v0_y,
  input  logic [WIDTH-1:0] sol_v1_x,
  input  logic [WIDTH-1:0] sol_v1_y
`ifdef COLLISION_STATS_EN
  ,
  output logic [15:0]      collision_count,
  output logic [15:0]      pairs_checked
`endif
);

  localparam int CW = IDX_W + 1;
  localparam int DW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 3;
  localparam int TW = $clog2(SOLVER_TIMEOUT + 1);
  localparam logic [CW-1:0] NB    = CW'(NUM_BALLS);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [TW-1:0] TLAST = TW'(SOLVER_TIMEOUT - 1);
  localparam logic signed [PW-1:0] THRESH = {{(PW-WIDTH){1'b0}}, DIAM_SQ} << FRAC_WIDTH;

  typedef enum logic [3:0] {
    IDLE  = 4'd0, RD_I = 4'd1, RD_J = 4'd2, CHECK = 4'd3, SOLVE = 4'd4,
    WAIT  = 4'd5, WB_I = 4'd6, WB_J = 4'd7, NEXT  = 4'd8, DONE  = 4'd9
  } state_t;

  state_t state_r, state_s;
  logic [CW-1:0] i_r, j_r, i_s, j_s, i_adv_s, j_adv_s, j_inc_s;
  logic last_s, start_ok_s, collide_s, timeout_hit_s;
  logic [TW-1:0] tmo_r;
  logic [WIDTH-1:0] bi_x_r, bi_y_r, bi_vx_r, bi_vy_r;
  logic [WIDTH-1:0] bj_x_r, bj_y_r, bj_vx_r, bj_vy_r;
  logic [WIDTH-1:0] res1_vx_r, res1_vy_r;
  logic signed [DW-1:0] dx_s, dy_s, dvx_s, dvy_s;
  logic signed [PW-1:0] dxe_s, dye_s, dvxe_s, dvye_s, d2_s, dot_s;
  logic busy_s, pass_done_s, rd_en_s, wr_en_s, sol_start_s;
  logic [IDX_W-1:0] rd_addr_s, wr_addr_s;
  logic [WIDTH-1:0] wr_vx_s, wr_vy_s;

  assign start_ok_s    = (state_r == IDLE) && start;
  assign timeout_hit_s = (tmo_r == TLAST);

  assign sol_x0  = bi_x_r;
  assign sol_y0  = bi_y_r;
  assign sol_vx0 = bi_vx_r;
  assign sol_vy0 = bi_vy_r;
  assign sol_x1  = bj_x_r;
  assign sol_y1  = bj_y_r;
  assign sol_vx1 = bj_vx_r;
  assign sol_vy1 = bj_vy_r;

  // State register and registered control/data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      rd_en     <= 1'b0;
      wr_en     <= 1'b0;
      sol_start <= 1'b0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_vx     <= '0;
      wr_vy     <= '0;
    end else begin
      state_r   <= state_s;
      busy      <= busy_s;
      pass_done <= pass_done_s;
      rd_en     <= rd_en_s;
      wr_en     <= wr_en_s;
      sol_start <= sol_start_s;
      rd_addr   <= rd_addr_s;
      wr_addr   <= wr_addr_s;
      wr_vx     <= wr_vx_s;
      wr_vy     <= wr_vy_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:  if (start) state_s = RD_I; else state_s = IDLE;
      RD_I:  state_s = RD_J;
      RD_J:  state_s = CHECK;
      CHECK: if (collide_s) state_s = SOLVE; else state_s = NEXT;
      SOLVE: state_s = WAIT;
      WAIT: begin
        if (sol_done)           state_s = WB_I;
        else if (timeout_hit_s) state_s = NEXT;
        else                    state_s = WAIT;
      end
      WB_I:  state_s = WB_J;
      WB_J:  state_s = NEXT;
      NEXT:  if (last_s) state_s = DONE; else state_s = RD_I;
      DONE:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Pair index advance; counters are one bit wider so j can reach NUM_BALLS=256
  always_comb begin
    j_inc_s = j_r + ONE;
    if (j_inc_s == NB) begin
      i_adv_s = i_r + ONE;
      j_adv_s = i_r + CW'(2);
    end else begin
      i_adv_s = i_r;
      j_adv_s = j_inc_s;
    end
    last_s = (i_adv_s == (NB - ONE));
    if (start_ok_s) begin
      i_s = '0;
      j_s = ONE;
    end else if (state_r == NEXT) begin
      i_s = i_adv_s;
      j_s = j_adv_s;
    end else begin
      i_s = i_r;
      j_s = j_r;
    end
  end

  // Pair test at full precision; ball j comes straight off the read port in CHECK
  always_comb begin
    dx_s   = {rd_x[WIDTH-1], rd_x}   - {bi_x_r[WIDTH-1], bi_x_r};
    dy_s   = {rd_y[WIDTH-1], rd_y}   - {bi_y_r[WIDTH-1], bi_y_r};
    dvx_s  = {rd_vx[WIDTH-1], rd_vx} - {bi_vx_r[WIDTH-1], bi_vx_r};
    dvy_s  = {rd_vy[WIDTH-1], rd_vy} - {bi_vy_r[WIDTH-1], bi_vy_r};
    dxe_s  = {{(PW-DW){dx_s[DW-1]}}, dx_s};
    dye_s  = {{(PW-DW){dy_s[DW-1]}}, dy_s};
    dvxe_s = {{(PW-DW){dvx_s[DW-1]}}, dvx_s};
    dvye_s = {{(PW-DW){dvy_s[DW-1]}}, dvy_s};
    d2_s   = dxe_s * dxe_s + dye_s * dye_s;
    dot_s  = dxe_s * dvxe_s + dye_s * dvye_s;
    // coincident balls give dot==0, so they never reach the solver
    collide_s = (d2_s < THRESH) && dot_s[PW-1];
  end

  // Output decode from the next state so the registered outputs line up with the state
  always_comb begin
    busy_s      = (state_s != IDLE);
    pass_done_s = (state_s == DONE);
    rd_en_s     = (state_s == RD_I) || (state_s == RD_J);
    wr_en_s     = (state_s == WB_I) || (state_s == WB_J);
    sol_start_s = (state_s == SOLVE);
    rd_addr_s   = rd_addr;
    wr_addr_s   = wr_addr;
    wr_vx_s     = wr_vx;
    wr_vy_s     = wr_vy;
    case (state_s)
      RD_I: rd_addr_s = i_s[IDX_W-1:0];
      RD_J: rd_addr_s = j_s[IDX_W-1:0];
      WB_I: begin
        wr_addr_s = i_r[IDX_W-1:0];
        wr_vx_s   = sol_v0_x;
        wr_vy_s   = sol_v0_y;
      end
      WB_J: begin
        wr_addr_s = j_r[IDX_W-1:0];
        wr_vx_s   = res1_vx_r;
        wr_vy_s   = res1_vy_r;
      end
      default: rd_addr_s = rd_addr;
    endcase
  end

  // Pair indices, latched ball state, solver results, timeout tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      i_r <= '0;  j_r <= '0;  tmo_r <= '0;  timeout_err <= 1'b0;
      bi_x_r <= '0;  bi_y_r <= '0;  bi_vx_r <= '0;  bi_vy_r <= '0;
      bj_x_r <= '0;  bj_y_r <= '0;  bj_vx_r <= '0;  bj_vy_r <= '0;
      res1_vx_r <= '0;  res1_vy_r <= '0;
    end else begin
      i_r <= i_s;
      j_r <= j_s;
      if (state_r == RD_J) begin
        bi_x_r <= rd_x;  bi_y_r <= rd_y;  bi_vx_r <= rd_vx;  bi_vy_r <= rd_vy;
      end
      if (state_r == CHECK) begin
        bj_x_r <= rd_x;  bj_y_r <= rd_y;  bj_vx_r <= rd_vx;  bj_vy_r <= rd_vy;
      end
      if (state_r == SOLVE)     tmo_r <= '0;
      else if (state_r == WAIT) tmo_r <= tmo_r + TW'(1);
      if (state_r == WAIT && sol_done) begin
        res1_vx_r <= sol_v1_x;
        res1_vy_r <= sol_v1_y;
      end
      if (start_ok_s)                                       timeout_err <= 1'b0;
      else if (state_r == WAIT && !sol_done && timeout_hit_s) timeout_err <= 1'b1;
    end
  end

`ifdef COLLISION_STATS_EN
  // Per-pass statistics, saturating, frozen between pass_done and the next start
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      collision_count <= 16'd0;
      pairs_checked   <= 16'd0;
    end else if (state_r == CHECK) begin
      if (pairs_checked != 16'hFFFF) pairs_checked <= pairs_checked + 16'd1;
      if (collide_s && collision_count != 16'hFFFF) collision_count <= collision_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Directed bench for collision_pair_scheduler with four balls, a latency-1 RAM model and a
// velocity-swapping solver model. Stats checks compile in under COLLISION_STATS_EN.
`timescale 1ns/1ps
module tb_collision_pair_scheduler;
  localparam int NB = 4;
  localparam int IW = 8;
  localparam logic [31:0] ZERO  = 32'h0000_0000;
  localparam logic [31:0] HALF  = 32'h2000_0000;  // +0.5
  localparam logic [31:0] NHALF = 32'hE000_0000;  // -0.5
  localparam logic [31:0] QUART = 32'h1000_0000;  // 0.25
  localparam logic [31:0] TQ    = 32'h3000_0000;  // 0.75
  localparam logic [31:0] DIAM  = 32'h0800_0000;  // sqrt(2^-6) in Q30
  localparam logic [31:0] RAD   = 32'h0400_0000;  // DIAM/2
  localparam logic [31:0] VY1   = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst, start, busy, pass_done, timeout_err, rd_en, wr_en, sol_start, sol_done;
  logic [IW-1:0] rd_addr, wr_addr;
  logic [31:0] rd_x, rd_y, rd_vx, rd_vy, wr_vx, wr_vy;
  logic [31:0] sol_x0, sol_y0, sol_vx0, sol_vy0, sol_x1, sol_y1, sol_vx1, sol_vy1;
  logic [31:0] sol_v0_x, sol_v0_y, sol_v1_x, sol_v1_y;
`ifdef COLLISION_STATS_EN
  logic [15:0] collision_count, pairs_checked;
`endif

  always #5 clk = ~clk;

  collision_pair_scheduler #(.NUM_BALLS(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .pass_done(pass_done),
    .timeout_err(timeout_err), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_vx(rd_vx), .rd_vy(rd_vy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_vx(wr_vx), .wr_vy(wr_vy),
    .sol_start(sol_start), .sol_x0(sol_x0), .sol_y0(sol_y0), .sol_vx0(sol_vx0),
    .sol_vy0(sol_vy0), .sol_x1(sol_x1), .sol_y1(sol_y1), .sol_vx1(sol_vx1),
    .sol_vy1(sol_vy1), .sol_done(sol_done), .sol_v0_x(sol_v0_x), .sol_v0_y(sol_v0_y),
    .sol_v1_x(sol_v1_x), .sol_v1_y(sol_v1_y)
`ifdef COLLISION_STATS_EN
    , .collision_count(collision_count), .pairs_checked(pairs_checked)
`endif
  );

  // Ball-state RAM: registered read, velocity write, bulk load from the stimulus arrays
  logic [31:0] mx[NB], my[NB], mvx[NB], mvy[NB];
  logic [31:0] lx[NB], ly[NB], lvx[NB], lvy[NB];
  logic ld = 1'b0;
  always @(posedge clk) begin
    if (ld) begin
      for (int k = 0; k < NB; k++) begin
        mx[k] <= lx[k];  my[k] <= ly[k];  mvx[k] <= lvx[k];  mvy[k] <= lvy[k];
      end
    end else if (wr_en) begin
      mvx[wr_addr[1:0]] <= wr_vx;
      mvy[wr_addr[1:0]] <= wr_vy;
    end
    if (rd_en) begin
      rd_x <= mx[rd_addr[1:0]];    rd_y <= my[rd_addr[1:0]];
      rd_vx <= mvx[rd_addr[1:0]];  rd_vy <= mvy[rd_addr[1:0]];
    end
  end

  // Solver model: swaps the two velocities, done pulse two cycles after the start edge
  logic sol_en = 1'b1;
  logic [2:0] scnt;
  logic [31:0] cap_x0, cap_x1, cap_vx0, cap_vy1;
  always @(posedge clk) begin
    if (rst) begin
      scnt <= 3'd0;  sol_done <= 1'b0;
    end else if (sol_start) begin
      scnt <= 3'd2;  sol_done <= 1'b0;
      cap_x0 <= sol_x0;  cap_x1 <= sol_x1;  cap_vx0 <= sol_vx0;  cap_vy1 <= sol_vy1;
    end else if (scnt != 3'd0) begin
      scnt <= scnt - 3'd1;
      sol_done <= (scnt == 3'd1) && sol_en;
    end else begin
      sol_done <= 1'b0;
    end
  end
  assign sol_v0_x = sol_vx1;
  assign sol_v0_y = sol_vy1;
  assign sol_v1_x = sol_vx0;
  assign sol_v1_y = sol_vy0;

  int checks = 0;
  int fails = 0;
  int n_cyc, n_sst, n_wr, n_pd, n_both, n_busy, n_busy_tail;
  logic [IW-1:0] wa[4];
  logic [31:0] wvx[4], wvy[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply_load();
    @(negedge clk); ld = 1'b1;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic load_cfg(input logic [31:0] x1, input logic [31:0] vx0);
    lx = '{ZERO, x1, HALF, TQ};
    ly = '{ZERO, ZERO, ZERO, ZERO};
    lvx = '{vx0, ZERO, ZERO, ZERO};
    lvy = '{ZERO, VY1, ZERO, ZERO};
    apply_load();
  endtask

  // One pass: start, tally outputs until pass_done (bounded), then a tail window
  task automatic run_pass(input int poke_at, input bit poke_done, input int tail);
    bit seen = 1'b0;
    n_cyc = 0; n_sst = 0; n_wr = 0; n_pd = 0; n_both = 0; n_busy = 0; n_busy_tail = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 400 && !seen; c++) begin
      start = (c == poke_at);
      @(posedge clk); #1;
      n_cyc = c;
      if (sol_start) n_sst++;
      if (busy) n_busy++;
      if (rd_en && wr_en) n_both++;
      if (wr_en) begin
        if (n_wr < 4) begin wa[n_wr] = wr_addr; wvx[n_wr] = wr_vx; wvy[n_wr] = wr_vy; end
        n_wr++;
      end
      if (pass_done) begin n_pd++; seen = 1'b1; end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin fails++; $display("FAIL pass_timeout: got no pass_done expected one"); end
    for (int t = 0; t < tail; t++) begin
      start = (t == 0) && poke_done;
      @(posedge clk); #1;
      start = 1'b0;
      if (pass_done) n_pd++;
      if (busy) n_busy_tail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pass_done", {31'd0, pass_done}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_sol_start", {31'd0, sol_start}, 32'd0);
    chk("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_sol_x0", sol_x0, 32'd0);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_far();
    lx = '{ZERO, QUART, HALF, TQ};
    ly = '{ZERO, ZERO, ZERO, ZERO};
    lvx = '{HALF, NHALF, HALF, NHALF};
    lvy = '{ZERO, ZERO, ZERO, ZERO};
    apply_load();
    run_pass(0, 1'b0, 4);
    chk("far_cycles", n_cyc, 32'd24);
    chk("far_busy_cycles", n_busy, 32'd24);
    chk("far_sol_start", n_sst, 32'd0);
    chk("far_writes", n_wr, 32'd0);
    chk("far_pass_done", n_pd, 32'd1);
    chk("far_busy_after", n_busy_tail, 32'd0);
  endtask

  task automatic test_collide();
    load_cfg(RAD, HALF);
    run_pass(0, 1'b0, 2);
    chk("col_cycles", n_cyc, 32'd30);
    chk("col_sol_start", n_sst, 32'd1);
    chk("col_op_x0", cap_x0, ZERO);
    chk("col_op_x1", cap_x1, RAD);
    chk("col_op_vx0", cap_vx0, HALF);
    chk("col_op_vy1", cap_vy1, VY1);
    chk("col_writes", n_wr, 32'd2);
    chk("col_wa0", {24'd0, wa[0]}, 32'd0);
    chk("col_wvx0", wvx[0], ZERO);
    chk("col_wvy0", wvy[0], VY1);
    chk("col_wa1", {24'd0, wa[1]}, 32'd1);
    chk("col_wvx1", wvx[1], HALF);
    chk("col_wvy1", wvy[1], ZERO);
    chk("col_rd_wr_overlap", n_both, 32'd0);
    chk("col_mem_vx1", mvx[1], HALF);
`ifdef COLLISION_STATS_EN
    chk("col_stat_collisions", {16'd0, collision_count}, 32'd1);
    chk("col_stat_pairs", {16'd0, pairs_checked}, 32'd6);
`endif
  endtask

  task automatic test_separating();
    load_cfg(RAD, NHALF);
    run_pass(0, 1'b0, 2);
    chk("sep_cycles", n_cyc, 32'd24);
    chk("sep_sol_start", n_sst, 32'd0);
    chk("sep_writes", n_wr, 32'd0);
  endtask

  task automatic test_timeout();
    sol_en = 1'b0;
    load_cfg(RAD, HALF);
    run_pass(0, 1'b0, 2);
    chk("tmo_cycles", n_cyc, 32'd89);
    chk("tmo_sol_start", n_sst, 32'd1);
    chk("tmo_writes", n_wr, 32'd0);
    chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
    sol_en = 1'b1;
    run_pass(0, 1'b0, 2);
    chk("tmo_err_cleared", {31'd0, timeout_err}, 32'd0);
    chk("tmo_retry_writes", n_wr, 32'd2);
  endtask

  task automatic test_reset_mid_pass();
    bit hit = 1'b0;
    sol_en = 1'b0;
    load_cfg(RAD, HALF);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      if (sol_start) hit = 1'b1;
    end
    chk("rmid_reached_solve", {31'd0, hit}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_sol_start", {31'd0, sol_start}, 32'd0);
    chk("rmid_wr_en", {31'd0, wr_en}, 32'd0);
    @(negedge clk); rst = 1'b0;
    sol_en = 1'b1;
    load_cfg(RAD, HALF);
    run_pass(0, 1'b0, 2);
    chk("rmid_clean_cycles", n_cyc, 32'd30);
    chk("rmid_clean_writes", n_wr, 32'd2);
    chk("rmid_clean_pass_done", n_pd, 32'd1);
  endtask

  task automatic test_back_to_back();
    // d2 exactly equals the threshold; extra starts land mid-pass and on the DONE cycle
    load_cfg(DIAM, HALF);
    run_pass(5, 1'b1, 40);
    chk("b2b_cycles", n_cyc, 32'd24);
    chk("b2b_pass_done", n_pd, 32'd1);
    chk("b2b_busy_after", n_busy_tail, 32'd0);
    chk("thr_sol_start", n_sst, 32'd0);
    chk("thr_writes", n_wr, 32'd0);
`ifdef COLLISION_STATS_EN
    chk("thr_stat_collisions", {16'd0, collision_count}, 32'd0);
    chk("thr_stat_pairs", {16'd0, pairs_checked}, 32'd6);
`endif
  endtask

  initial begin
    test_reset();
    test_far();
    test_collide();
    test_separating();
    test_timeout();
    test_reset_mid_pass();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
